// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and stream field widths.
// Imported by the loader, its word assembler and its interface.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master = stream source / memory side, slave = loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [WORD_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs payload bytes into a little-endian word
// and keeps the running XOR checksum.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              stb_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              lane3_o,
  output logic [BYTE_W-1:0] csum_o
);

  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clr_i) begin
      lane_d = '0;
      word_d = '0;
      csum_d = '0;
    end else if (stb_i) begin
      word_d[{lane_q, 3'b000} +: BYTE_W] = byte_i;
      csum_d = csum_q ^ byte_i;
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word_o  = word_q;
  assign lane3_o = (lane_q == 2'd3);
  assign csum_o  = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, XOR-checked byte image
// into word writes; holds the core until verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [LEN_W:0] MAX_N = (LEN_W+1)'(2**ADDR_W);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              xfer, clr, stb;
  logic              lane3, len_bad, last;
  logic [LEN_W-1:0]  len_full;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] csum;

  assign xfer     = bus.rx_valid && bus.rx_ready;
  assign len_full = {bus.rx_data, len_q[BYTE_W-1:0]};
  assign len_bad  = (len_full == '0)
                 || ({1'b0, len_full} > MAX_N);
  assign last     = (LEN_W'(idx_q) == len_q - LEN_W'(1));
  assign clr      = start
                 && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign stb      = xfer && (state_q == S_DATA);

  word_assembler u_asm (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr),
    .stb_i   (stb),
    .byte_i  (bus.rx_data),
    .word_o  (word),
    .lane3_o (lane3),
    .csum_o  (csum)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          idx_d   = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[BYTE_W-1:0] = bus.rx_data;
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d   = len_full;
          state_d = len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && lane3) state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = last ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer)
          state_d = (bus.rx_data == csum) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.rx_ready = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
  assign bus.wr_en    = (state_q == S_WRITE);
  assign bus.wr_addr  = WORD_W'({idx_q, 2'b00});
  assign bus.wr_data  = word;

  assign busy     = state_q inside {S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK};
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a stream-level
// reference model checked every cycle.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, err;

  imem_loader_if bus();

  imem_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Stream-level model: status 0 idle, 1 busy, 2 done, 3 err
  bit          mv = 0;
  int          st = 0;
  int          pos, n, k;
  logic [7:0]  acc, b;
  logic [31:0] mw, eaddr, edata;
  bit          ewr = 0;
  bit          rstv = 0;
  bit          mready;
  int          dut_wr = 0;
  logic [31:0] mlog[$];

  always @(negedge clk) begin
    if (mv) begin
      chk("wr_en", bus.wr_en, ewr);
      if (ewr) begin
        chk("wr_addr", bus.wr_addr, eaddr);
        chk("wr_data", bus.wr_data, edata);
      end
      if (rstv) begin
        chk("idle_wr_addr", bus.wr_addr, 32'h0);
        chk("idle_wr_data", bus.wr_data, 32'h0);
      end
      chk("rx_ready", bus.rx_ready, st == 1 && !ewr);
      chk("busy", busy, st == 1);
      chk("done", done, st == 2);
      chk("err", err, st == 3);
      chk("cpu_hold", cpu_hold, st != 2);
    end
    if (bus.wr_en === 1'b1) dut_wr++;
    mready = (st == 1) && !ewr;
    if (!reset_n) begin
      st = 0; ewr = 0; rstv = 1; mv = 1;
    end else if (start && st != 1) begin
      st = 1; pos = 0; acc = 0; ewr = 0; rstv = 0;
    end else if (st == 1 && ewr) begin
      ewr = 0;
    end else if (mready && bus.rx_valid) begin
      b = bus.rx_data;
      if (pos == 0) begin
        n = int'(b);
      end else if (pos == 1) begin
        n = n + int'(b) * 256;
        if (n == 0 || n > 256) st = 3;
      end else if (pos < 2 + 4 * n) begin
        k = pos - 2;
        mw[(k % 4) * 8 +: 8] = b;
        acc = acc ^ b;
        if (k % 4 == 3) begin
          ewr   = 1;
          eaddr = 32'((k / 4) * 4);
          edata = mw;
          mlog.push_back(edata);
        end
      end else begin
        st = (b == acc) ? 2 : 3;
      end
      pos++;
    end
  end

  task automatic step(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send(input bq_t s, input bit gappy);
    foreach (s[i]) begin
      int  t;
      bit  xf;
      t  = 0;
      xf = 0;
      do begin
        bus.rx_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rx_data  = s[i];
        @(negedge clk);
        xf = bus.rx_valid && bus.rx_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!xf && t < 64);
      if (!xf) begin
        vecs++;
        miss++;
        $display("FAIL rx_timeout: byte %0d not taken in %0d cycles", i, t);
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  bq_t img, bad, tmp;
  int  w0;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    img = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00,
            8'hB3, 8'h02, 8'h11, 8'h40, 8'hC0};
    bad = img;
    bad[10] = 8'hC1;

    // Reset with a byte already offered
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    step(3);
    chk("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    reset_n = 1'b1;
    bus.rx_valid = 1'b0;
    step(2);

    // Two-word load at full rate
    mlog.delete();
    w0 = dut_wr;
    pulse_start();
    send(img, 1'b0);
    step(2);
    chk("s2_done", done, 1'b1);
    chk("s2_hold", cpu_hold, 1'b0);
    chk("s2_err", err, 1'b0);
    chk("s2_nwr", 32'(dut_wr - w0), 32'd2);
    chk("s2_mlog_n", 32'(mlog.size()), 32'd2);
    chk("s2_w0", mlog.size() > 0 ? mlog[0] : 32'hx, 32'h00110233);
    chk("s2_w1", mlog.size() > 1 ? mlog[1] : 32'hx, 32'h401102B3);

    // Backpressure, restarted from DONE
    mlog.delete();
    w0 = dut_wr;
    pulse_start();
    send(img, 1'b1);
    step(2);
    chk("s3_done", done, 1'b1);
    chk("s3_nwr", 32'(dut_wr - w0), 32'd2);
    chk("s3_w1", mlog.size() > 1 ? mlog[1] : 32'hx, 32'h401102B3);

    // Bad checksum
    w0 = dut_wr;
    pulse_start();
    send(bad, 1'b0);
    step(2);
    chk("s4_err", err, 1'b1);
    chk("s4_done", done, 1'b0);
    chk("s4_hold", cpu_hold, 1'b1);
    chk("s4_rx_ready", bus.rx_ready, 1'b0);
    chk("s4_nwr", 32'(dut_wr - w0), 32'd2);

    // Illegal lengths: zero and 257
    w0 = dut_wr;
    pulse_start();
    tmp = '{8'h00, 8'h00};
    send(tmp, 1'b0);
    step(2);
    chk("s5a_err", err, 1'b1);
    chk("s5a_nwr", 32'(dut_wr - w0), 32'd0);
    pulse_start();
    tmp = '{8'h01, 8'h01};
    send(tmp, 1'b0);
    step(2);
    chk("s5b_err", err, 1'b1);
    chk("s5b_nwr", 32'(dut_wr - w0), 32'd0);
    pulse_start();
    send(img, 1'b0);
    step(2);
    chk("s5c_done", done, 1'b1);

    // Reset after two payload bytes, then reload
    pulse_start();
    tmp = '{8'h02, 8'h00, 8'h33, 8'h02};
    send(tmp, 1'b0);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("s6_busy", busy, 1'b0);
    chk("s6_wr_addr", bus.wr_addr, 32'h0);
    chk("s6_wr_data", bus.wr_data, 32'h0);
    chk("s6_hold", cpu_hold, 1'b1);
    step(1);
    mlog.delete();
    w0 = dut_wr;
    pulse_start();
    send(img, 1'b0);
    step(2);
    chk("s6_done", done, 1'b1);
    chk("s6_nwr", 32'(dut_wr - w0), 32'd2);
    chk("s6_w0", mlog.size() > 0 ? mlog[0] : 32'hx, 32'h00110233);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
